// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one memory port between an instruction-fetch
// requester and a data (load/store) requester.
//
// Data requests have priority. When built with ARB_STARVE_GUARD_EN defined,
// a waiting fetch is forced through after STARVE_LIMIT consecutive data
// grants. Without the macro, arbitration is strict data priority.
//
// Each transaction takes MEM_LAT+1 cycles: one grant cycle in IDLE, then
// MEM_LAT busy cycles. The last busy cycle returns data and pulses *_valid.
//
// Parameters
//   MEM_LAT       memory read latency, 1..7
//   STARVE_LIMIT  max consecutive data grants while a fetch waits, 1..15
// Ports
//   clock, reset                   clock, synchronous active-high reset
//   if_req/if_addr                 fetch request (held until if_valid)
//   if_gnt/if_valid/if_rdata       fetch accept, completion, data
//   dm_req/rw/size/addr/wdata      data request (held until dm_valid)
//   dm_gnt/dm_valid/dm_rdata       data accept, completion, load data
//   mem_addr/wdata/rw/size         shared memory port
//   mem_rdata                      memory read data
//   stall_if, stall_dm             pipeline stalls
module mem_arbiter #(
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_rw,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_dm
);

  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT out of range 1..7");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("mem_arbiter: STARVE_LIMIT out of range 1..15");
  end

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  state_t      state, state_nxt;
  logic [2:0]  lat_cnt;
  logic [31:0] if_addr_q, dm_addr_q, dm_wdata_q;
  logic        dm_rw_q;
  logic [1:0]  dm_size_q;

  logic starve_ovr;
  logic grant_dm, grant_if, last_cyc;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  assign starve_ovr = if_req && (starve_cnt == STARVE_MAX);

  // Counts data grants taken while a fetch was waiting; saturates so the
  // override stays armed until the fetch actually wins.
  always_ff @(posedge clock) begin
    if (reset)
      starve_cnt <= '0;
    else if (grant_if)
      starve_cnt <= '0;
    else if (grant_dm && if_req && starve_cnt != STARVE_MAX)
      starve_cnt <= starve_cnt + 4'd1;
  end
`else
  assign starve_ovr = 1'b0;
`endif

  // Grants are suppressed during reset so nothing is accepted in that cycle.
  assign grant_dm = !reset && (state == IDLE) && dm_req && !starve_ovr;
  assign grant_if = !reset && (state == IDLE) && if_req && !grant_dm;
  assign last_cyc = (state != IDLE) && (lat_cnt == 3'd0);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      if_addr_q  <= '0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_rw_q    <= 1'b0;
      dm_size_q  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_dm) begin
        lat_cnt    <= LAT_LOAD;
        dm_addr_q  <= dm_addr;
        dm_wdata_q <= dm_wdata;
        dm_rw_q    <= dm_rw;
        dm_size_q  <= dm_size;
      end else if (grant_if) begin
        lat_cnt   <= LAT_LOAD;
        if_addr_q <= if_addr;
      end else if (state != IDLE && lat_cnt != 3'd0) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_dm)      state_nxt = DM_BUSY;
        else if (grant_if) state_nxt = IF_BUSY;
      end
      IF_BUSY, DM_BUSY: if (lat_cnt == 3'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. During reset the busy state may still be registered, so
  // every output is forced to its idle value to abandon the transaction.
  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if_valid  = 1'b0;
    dm_valid  = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rw    = 1'b0;
    mem_size  = 2'b10;
    if (!reset) begin
      if_gnt = grant_if;
      dm_gnt = grant_dm;
      case (state)
        IF_BUSY: begin
          mem_addr = if_addr_q;
          if (last_cyc) begin
            if_valid = 1'b1;
            if_rdata = mem_rdata;
          end
        end
        DM_BUSY: begin
          mem_addr  = dm_addr_q;
          mem_wdata = dm_wdata_q;
          mem_size  = dm_size_q;
          if (last_cyc) begin
            dm_valid = 1'b1;
            dm_rdata = mem_rdata;
            mem_rw   = dm_rw_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_if = if_req & ~if_valid;
  assign stall_dm = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk, rst;
  logic        if_req, dm_req, dm_rw;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [1:0]  dm_size;

  logic        if_gnt1, if_valid1, dm_gnt1, dm_valid1, mem_rw1, stall_if1, stall_dm1;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic [1:0]  mem_size1;
  logic        if_gnt3, if_valid3, dm_gnt3, dm_valid3, mem_rw3, stall_if3, stall_dm3;
  logic [31:0] if_rdata3, dm_rdata3, mem_addr3, mem_wdata3;
  logic [1:0]  mem_size3;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(4)) u1 (
    .clock(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_valid(if_valid1), .if_rdata(if_rdata1),
    .dm_req(dm_req), .dm_rw(dm_rw), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt1), .dm_valid(dm_valid1), .dm_rdata(dm_rdata1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rw(mem_rw1), .mem_size(mem_size1),
    .mem_rdata(mem_rdata), .stall_if(stall_if1), .stall_dm(stall_dm1));

  mem_arbiter #(.MEM_LAT(3), .STARVE_LIMIT(4)) u3 (
    .clock(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_valid(if_valid3), .if_rdata(if_rdata3),
    .dm_req(dm_req), .dm_rw(dm_rw), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt3), .dm_valid(dm_valid3), .dm_rdata(dm_rdata3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rw(mem_rw3), .mem_size(mem_size3),
    .mem_rdata(mem_rdata), .stall_if(stall_if3), .stall_dm(stall_dm3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
  //  mem_addr, mem_wdata, mem_rw, mem_size, stall_if, stall_dm}
  typedef logic [136:0] obs_t;

  obs_t act1, act3;
  assign act1 = {if_gnt1, if_valid1, if_rdata1, dm_gnt1, dm_valid1, dm_rdata1,
                 mem_addr1, mem_wdata1, mem_rw1, mem_size1, stall_if1, stall_dm1};
  assign act3 = {if_gnt3, if_valid3, if_rdata3, dm_gnt3, dm_valid3, dm_rdata3,
                 mem_addr3, mem_wdata3, mem_rw3, mem_size3, stall_if3, stall_dm3};

  function automatic obs_t mk(input logic ig, input logic iv, input logic [31:0] ird,
                              input logic dg, input logic dv, input logic [31:0] drd,
                              input logic [31:0] ma, input logic [31:0] mwd,
                              input logic mrw, input logic [1:0] msz,
                              input logic sif, input logic sdm);
    return {ig, iv, ird, dg, dv, drd, ma, mwd, mrw, msz, sif, sdm};
  endfunction

  typedef struct {
    string       name;
    logic        ir;
    logic [31:0] ia;
    logic        dr, drw;
    logic [1:0]  dsz;
    logic [31:0] da, dwd, mrd;
    obs_t        exp;
  } vec_t;

  task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic drw,
                       input logic [1:0] dsz, input logic [31:0] da, input logic [31:0] dwd,
                       input logic [31:0] mrd);
    if_req = ir; if_addr = ia; dm_req = dr; dm_rw = drw;
    dm_size = dsz; dm_addr = da; dm_wdata = dwd; mem_rdata = mrd;
  endtask

  vec_t vecs[10];

  initial begin
    int tx, n_if, n_dm, clash;
    logic [15:0] if_pat, exp_pat;
    logic [3:0]  rw_pat, v_pat, g_pat;
    logic [31:0] wd_seen, ad_seen;

    vecs[0] = '{"if_c0",   1, 32'h01000000, 0, 0, 2'b10, 0, 0, 32'h13,
                mk(1,0,0, 0,0,0, 0,0,0,2'b10, 1,0)};
    vecs[1] = '{"if_c1",   1, 32'h01000000, 0, 0, 2'b10, 0, 0, 32'h13,
                mk(0,1,32'h13, 0,0,0, 32'h01000000,0,0,2'b10, 0,0)};
    vecs[2] = '{"idle_a",  0, 0, 0, 0, 2'b10, 0, 0, 32'h13,
                mk(0,0,0, 0,0,0, 0,0,0,2'b10, 0,0)};
    vecs[3] = '{"both_c0", 1, 32'h01000000, 1, 0, 2'b10, 32'h01000100, 0, 32'hCAFE0001,
                mk(0,0,0, 1,0,0, 0,0,0,2'b10, 1,1)};
    vecs[4] = '{"both_c1", 1, 32'h01000000, 1, 0, 2'b10, 32'h01000100, 0, 32'hCAFE0001,
                mk(0,0,0, 0,1,32'hCAFE0001, 32'h01000100,0,0,2'b10, 1,0)};
    vecs[5] = '{"both_c2", 1, 32'h01000000, 0, 0, 2'b10, 0, 0, 32'hCAFE0001,
                mk(1,0,0, 0,0,0, 0,0,0,2'b10, 1,0)};
    vecs[6] = '{"both_c3", 1, 32'h01000000, 0, 0, 2'b10, 0, 0, 32'hCAFE0001,
                mk(0,1,32'hCAFE0001, 0,0,0, 32'h01000000,0,0,2'b10, 0,0)};
    vecs[7] = '{"sb_c0",   0, 0, 1, 1, 2'b00, 32'h10, 32'hAB, 0,
                mk(0,0,0, 1,0,0, 0,0,0,2'b10, 0,1)};
    vecs[8] = '{"sb_c1",   0, 0, 1, 1, 2'b00, 32'h10, 32'hAB, 0,
                mk(0,0,0, 0,1,0, 32'h10,32'hAB,1,2'b00, 0,0)};
    vecs[9] = '{"idle_b",  0, 0, 0, 0, 2'b10, 0, 0, 0,
                mk(0,0,0, 0,0,0, 0,0,0,2'b10, 0,0)};

    // Reset with both requesters active: no grants, idle memory port.
    rst = 1'b1;
    drive(1, 32'h01000000, 1, 0, 2'b10, 32'h01000100, 0, 0);
    @(negedge clk); #1;
    chk("reset_u1", act1, mk(0,0,0, 0,0,0, 0,0,0,2'b10, 1,1));
    chk("reset_u3", act3, mk(0,0,0, 0,0,0, 0,0,0,2'b10, 1,1));
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 2'b10, 0, 0, 0);

    // Table vectors on the MEM_LAT=1 instance, one cycle per row.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].drw,
            vecs[i].dsz, vecs[i].da, vecs[i].dwd, vecs[i].mrd);
      #1;
      chk(vecs[i].name, act1, vecs[i].exp);
    end

    // Both requesters held continuously for 20 cycles = 10 transactions.
    tx = 0; n_if = 0; n_dm = 0; clash = 0; if_pat = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive(1, 32'h100, 1, 0, 2'b10, 32'h200, 0, 0);
      #1;
      if (if_gnt1 && dm_gnt1) clash++;
      if (if_gnt1) begin
        if (tx < 16) if_pat[tx] = 1'b1;
        n_if++; tx++;
      end else if (dm_gnt1) begin
        n_dm++; tx++;
      end
    end
`ifdef ARB_STARVE_GUARD_EN
    exp_pat = 16'h0210;
`else
    exp_pat = 16'h0000;
`endif
    chk("starve_tx_count", 137'(tx), 137'(10));
    chk("starve_if_pattern", 137'(if_pat), 137'(exp_pat));
    chk("starve_dm_count", 137'(n_dm), 137'(10 - $countones(exp_pat)));
    chk("grant_exclusive", 137'(clash), 137'(0));

    // Clean restart for the MEM_LAT=3 sequences.
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 2'b10, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Store word, MEM_LAT=3: grant cycle 0, write strobe and valid cycle 3.
    rw_pat = '0; v_pat = '0; g_pat = '0; wd_seen = '0; ad_seen = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(0, 0, 1, 1, 2'b10, 32'h01000200, 32'hDEADBEEF, 0);
      #1;
      rw_pat[c] = mem_rw3;
      v_pat[c]  = dm_valid3;
      g_pat[c]  = dm_gnt3;
      if (c == 1) ad_seen = mem_addr3;
      if (c == 3) wd_seen = mem_wdata3;
    end
    chk("sw3_rw_pattern", 137'(rw_pat), 137'(4'b1000));
    chk("sw3_valid_pattern", 137'(v_pat), 137'(4'b1000));
    chk("sw3_gnt_pattern", 137'(g_pat), 137'(4'b0001));
    chk("sw3_wdata", 137'(wd_seen), 137'(32'hDEADBEEF));
    chk("sw3_addr", 137'(ad_seen), 137'(32'h01000200));
    @(negedge clk);
    drive(0, 0, 0, 0, 2'b10, 0, 0, 0);
    #1;
    chk("sw3_after", act3, mk(0,0,0, 0,0,0, 0,0,0,2'b10, 0,0));

    // Reset in the second DM_BUSY cycle of a write abandons it.
    @(negedge clk);
    drive(0, 0, 1, 1, 2'b10, 32'h01000300, 32'h12345678, 0);
    #1;
    chk("rst_mid_gnt", 137'(dm_gnt3), 137'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_cycle", act3, mk(0,0,0, 0,0,0, 0,0,0,2'b10, 0,1));
    @(negedge clk);
    rst = 1'b0;
    #1;
    // Back in IDLE: the still-held request is granted afresh, no completion.
    chk("rst_mid_next", {dm_gnt3, dm_valid3, mem_rw3, mem_addr3}, {1'b1, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    drive(0, 0, 0, 0, 2'b10, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, memory read latency in cycles; legal range 1..7.
REQ-002 Parameter STARVE_LIMIT, default 4, maximum consecutive data grants while a fetch waits; legal range 1..15.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  fetch request; held with if_addr stable until if_valid.
REQ-006 if_addr  input  32  fetch address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_valid  output  1  fetch complete; if_rdata valid this cycle.
REQ-009 if_rdata  output  32  fetched instruction.
REQ-010 dm_req, dm_rw, dm_size[1:0], dm_addr[31:0], dm_wdata[31:0]  input  data request; rw 1=write; size 00 byte, 01 half, 10 word; all held stable until dm_valid.
REQ-011 dm_gnt, dm_valid  output  1 each  data accept / completion (completion also acks writes).
REQ-012 dm_rdata  output  32  load data.
REQ-013 mem_addr[31:0], mem_wdata[31:0], mem_rw[1], mem_size[2]  output  shared memory port.
REQ-014 mem_rdata  input  32  memory read data, valid MEM_LAT cycles after address presented.
REQ-015 stall_if, stall_dm  output  1 each  pipeline stall to fetch / memory stage.

Function
REQ-016 FSM states IDLE, IF_BUSY, DM_BUSY; 3-bit latency counter lat_cnt.
REQ-017 IDLE: dm_req and no starvation override -> dm_gnt=1 (combinational), latch dm fields, go DM_BUSY; else if_req -> if_gnt=1, latch if_addr, go IF_BUSY; neither -> stay IDLE.
REQ-018 Starvation override: starve_cnt==STARVE_LIMIT and if_req -> fetch granted even if dm_req.
REQ-019 starve_cnt increments (saturating at STARVE_LIMIT) on each dm grant while if_req is high; clears on if grant; unchanged otherwise.
REQ-020 BUSY states last exactly MEM_LAT cycles; lat_cnt loads MEM_LAT-1 on grant, decrements each BUSY cycle.
REQ-021 During BUSY, mem_addr/mem_size/mem_wdata driven from latched fields; fetch size is fixed 2'b10, fetch mem_rw=0.
REQ-022 mem_rw=1 only in the final DM_BUSY cycle of a write; 0 in all other cycles.
REQ-023 Final BUSY cycle: corresponding *_valid=1 for one cycle, *_rdata=mem_rdata; next state IDLE.
REQ-024 Transaction occupies MEM_LAT+1 cycles (grant + BUSY); back-to-back throughput one per MEM_LAT+1 cycles.
REQ-025 IDLE/non-completing cycles: mem_addr=0, mem_wdata=0, mem_size=2'b10, mem_rw=0, *_rdata=0.
REQ-026 Requester dropping req mid-transaction: transaction still completes, valid still pulses.
REQ-027 Grants only in IDLE; at most one of if_gnt/dm_gnt high in any cycle.
REQ-028 stall_if = if_req & ~if_valid; stall_dm = dm_req & ~dm_valid (combinational).

Reset
REQ-029 Reset: state IDLE, lat_cnt=0, starve_cnt=0, latched fields 0; all outputs as REQ-025 with gnt/valid=0 in the reset cycle.
REQ-030 Reset mid-transaction abandons it: no valid pulse, no memory write issued.

Configuration
REQ-031 Macro ARB_STARVE_GUARD_EN defined: starvation override per REQ-018/019 active.
REQ-032 Macro undefined: strict data priority, starve_cnt and STARVE_LIMIT logic absent, fetch granted only when dm_req low in IDLE.

Verification
REQ-033 MEM_LAT=1, if_req only, if_addr=0x01000000, mem_rdata=0x00000013 -> if_gnt cycle 0, if_valid+if_rdata=0x00000013 cycle 1, stall_if high cycle 0 only.
REQ-034 if_req and dm_req (load, 0x01000100) asserted same cycle -> dm_gnt first, dm_valid cycle 1, if_gnt cycle 2, if_valid cycle 3.
REQ-035 dm_req continuous, if_req continuous, guard enabled, STARVE_LIMIT=4 -> exactly 4 dm grants then 1 if grant, pattern repeats; guard disabled -> zero if grants.
REQ-036 MEM_LAT=3 store word 0xDEADBEEF to 0x01000200 -> mem_rw=1 only in cycle 3, dm_valid cycle 3, mem_wdata=0xDEADBEEF.
REQ-037 reset asserted in second DM_BUSY cycle of a write (MEM_LAT=3) -> no mem_rw pulse, no dm_valid, IDLE next cycle.
